// File: rtl/bus_owner_arbiter.sv
// Round-robin owner of the shared 32-bit tri-state result bus.
//
// The bus is built from N groups of 74x244 buffers, one group per source,
// each with an active-low group enable. This block grants the bus to one
// requester at a time and drives those enables. A one-cycle all-off gap is
// always inserted between two owners (break-before-make), so two sources
// are never enabled together.
//
// Ports:
//   clk    system clock, rising edge
//   rst    synchronous reset, active-high
//   req    per-source level request, held for the whole transfer
//   g      active-low buffer enables, g[i] = 0 means source i drives the bus
//   gnt    active-high one-hot grant, always ~g
//   busy   bus currently owned
//   owner  index of the current owner, 0 when not busy
//
// All outputs are registered.
module bus_owner_arbiter #(
  parameter int unsigned N        = 8,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned IW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  g,
  output logic [N-1:0]  gnt,
  output logic          busy,
  output logic [IW-1:0] owner
);

  // Tenure counter must be able to hold MAX_HOLD itself (it saturates there).
  localparam int unsigned TW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [TW-1:0] HoldMax  = TW'(MAX_HOLD);
  localparam logic [TW-1:0] HoldLast = (MAX_HOLD > 0) ? TW'(MAX_HOLD - 1) : '0;
  localparam logic [IW-1:0] LastIdx  = IW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StTurn
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   ptr_q;
  logic [TW-1:0]   tenure_q;
  logic [N-1:0]    gnt_q;
  logic [N-1:0]    g_q;
  logic            busy_q;
  logic [IW-1:0]   owner_q;

  // Rotating-priority search starting at ptr_q.
  logic            any_req;
  logic [IW-1:0]   winner;
  logic [N-1:0]    winner_oh;

  always_comb begin
    logic [IW-1:0] idx;
    idx       = '0;
    any_req   = 1'b0;
    winner    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IW'((32'(ptr_q) + k) % N);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
    winner_oh         = '0;
    winner_oh[winner] = any_req;
  end

  logic          owner_req;
  logic          other_req;
  logic          release_bus;
  logic          preempt;
  logic [IW-1:0] next_ptr;

  always_comb begin
    owner_req   = |(req & gnt_q);
    other_req   = |(req & ~gnt_q);
    release_bus = !owner_req;
    // Threshold compare (not equality) so a waiter arriving after the counter
    // has saturated still forces a hand-off instead of starving.
    preempt     = (MAX_HOLD != 0) && (tenure_q >= HoldLast) && other_req;
    // Owner just served drops to lowest priority.
    next_ptr    = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      tenure_q <= '0;
      gnt_q    <= '0;
      g_q      <= '1;
      busy_q   <= 1'b0;
      owner_q  <= '0;
    end else begin
      case (state_q)
        // IDLE and TURN arbitrate identically; TURN only exists so that a
        // hand-off always spends one cycle with every enable off.
        StIdle, StTurn: begin
          if (any_req) begin
            state_q  <= StGrant;
            gnt_q    <= winner_oh;
            g_q      <= ~winner_oh;
            busy_q   <= 1'b1;
            owner_q  <= winner;
            tenure_q <= '0;
          end else begin
            state_q  <= StIdle;
          end
        end
        StGrant: begin
          if (release_bus || preempt) begin
            state_q  <= StTurn;
            gnt_q    <= '0;
            g_q      <= '1;
            busy_q   <= 1'b0;
            owner_q  <= '0;
            ptr_q    <= next_ptr;
            tenure_q <= '0;
          end else if (tenure_q != HoldMax) begin
            tenure_q <= tenure_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          gnt_q   <= '0;
          g_q     <= '1;
          busy_q  <= 1'b0;
          owner_q <= '0;
        end
      endcase
    end
  end

  assign g     = g_q;
  assign gnt   = gnt_q;
  assign busy  = busy_q;
  assign owner = owner_q;

endmodule
